// File: rtl/alu_sequencer.sv
// Instruction-issuing controller for a 4-bit ALU: 4x4-bit register file, IDLE/EXEC/RESP sequencing.
// Optional SKIPZ instruction enabled by defining ALU_SEQ_SKIPZ_EN; default build treats kind 11 as NOP.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [9:0] instr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_ALU   = 2'b00,
    K_LOADI = 2'b01,
    K_NOP   = 2'b10,
    K_SKIPZ = 2'b11
  } kind_e;

  state_e     state_q, state_d;
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_sel_q, alu_sel_d;
  logic [1:0] rd_q, rd_d;
  logic       res_valid_q, res_valid_d;
  logic [3:0] res_data_q, res_data_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       accept;
  logic       skip_now;
  kind_e      kind;

  assign kind   = kind_e'(instr[9:8]);
  assign accept = instr_valid && (state_q == S_IDLE);

`ifdef ALU_SEQ_SKIPZ_EN
  logic skip_q, skip_d;
  assign skip_now = skip_q;
`else
  assign skip_now = 1'b0;
`endif

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rd_d        = rd_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    c_d         = c_q;
    z_d         = z_q;
`ifdef ALU_SEQ_SKIPZ_EN
    skip_d      = skip_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept && skip_now) begin
`ifdef ALU_SEQ_SKIPZ_EN
          skip_d = 1'b0;
`endif
        end else if (accept) begin
          unique case (kind)
            K_ALU: begin
              // Operands are captured now, so rd == rs1/rs2 later sees the old value.
              alu_a_d   = regs_q[instr[3:2]];
              alu_b_d   = regs_q[instr[1:0]];
              alu_sel_d = instr[7:6];
              rd_d      = instr[5:4];
              state_d   = S_EXEC;
            end
            K_LOADI: regs_d[instr[5:4]] = instr[3:0];
            K_NOP:   ;
            K_SKIPZ: begin
`ifdef ALU_SEQ_SKIPZ_EN
              skip_d = z_q;
`endif
            end
            default: ;
          endcase
        end
      end

      S_EXEC: begin
        regs_d[rd_q] = alu_out;
        c_d          = alu_carry;
        z_d          = alu_zero;
        res_data_d   = alu_out;
        res_valid_d  = 1'b1;
        state_d      = S_RESP;
      end

      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      // NOTE: the register file is architecturally reset to zero, so it is built from resettable flops, not RAM.
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
`ifdef ALU_SEQ_SKIPZ_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rd_q        <= rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      c_q         <= c_d;
      z_q         <= z_d;
`ifdef ALU_SEQ_SKIPZ_EN
      skip_q      <= skip_d;
`endif
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  // The flags and the result flags are loaded at the same edge from the same source, so they share flops.
  assign res_carry   = c_q;
  assign res_zero    = z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized instructions against a
// transaction-level model. Build with +define+ALU_SEQ_SKIPZ_EN to exercise the SKIPZ variant.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry, alu_zero;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_carry, res_zero;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ALU_SEQ_SKIPZ_EN
  localparam bit SKIPZ_EN = 1'b1;
`else
  localparam bit SKIPZ_EN = 1'b0;
`endif

  // Reference model state: architectural registers, zero flag, pending skip.
  logic [3:0] m_regs [4];
  logic       m_z;
  logic       m_skip;
  logic [3:0] last_dut;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .busy(busy)
  );

  // Combinational ALU that the sequencer drives.
  logic [4:0] alu_sum;
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out   = (alu_sel == 2'd0) ? (alu_a & alu_b) :
                     (alu_sel == 2'd1) ? (alu_a | alu_b) :
                     (alu_sel == 2'd2) ? (alu_a ^ alu_b) : alu_sum[3:0];
  assign alu_carry = (alu_sel == 2'd3) && alu_sum[4];
  assign alu_zero  = (alu_out == 4'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_z    = 1'b0;
    m_skip = 1'b0;
  endtask

  function automatic logic [3:0] mk_alu(input int sel, input int rd, input int rs1, input int rs2);
    return {2'b00, 2'(sel), 2'(rd), 2'(rs1), 2'(rs2)};
  endfunction

  function automatic logic [3:0] mk_loadi(input int rd, input int imm);
    return 4'(0);
  endfunction

  // Issue one instruction while idle; for ALU ops, stall the response for `stall` cycles.
  task automatic issue(input logic [9:0] w, input int stall);
    logic [3:0] a, b, r;
    logic [4:0] s;
    logic       c;
    check("ready_before_issue", instr_ready, 1'b1);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = 10'($urandom);

    if (m_skip) begin
      m_skip = 1'b0;
      check("skipped_idle", busy, 1'b0);
    end else if (w[9:8] == 2'b00) begin
      a = m_regs[w[3:2]];
      b = m_regs[w[1:0]];
      s = {1'b0, a} + {1'b0, b};
      c = 1'b0;
      case (w[7:6])
        2'd0: r = a & b;
        2'd1: r = a | b;
        2'd2: r = a ^ b;
        default: begin r = s[3:0]; c = s[4]; end
      endcase
      check("exec_busy", busy, 1'b1);
      check("exec_ready", instr_ready, 1'b0);
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      check("exec_alu_sel", alu_sel, w[7:6]);
      check("exec_res_valid", res_valid, 1'b0);
      @(posedge clk); #1;
      check("resp_valid", res_valid, 1'b1);
      check("resp_data", res_data, r);
      check("resp_carry", res_carry, c);
      check("resp_zero", res_zero, (r == 4'd0));
      last_dut = res_data;
      for (int k = 0; k < stall; k++) begin
        instr_valid = 1'b1;
        instr       = 10'($urandom);
        @(posedge clk); #1;
        check("stall_valid", res_valid, 1'b1);
        check("stall_data", res_data, r);
        check("stall_ready", instr_ready, 1'b0);
      end
      instr_valid = 1'b0;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      res_ready   = 1'b0;
      check("done_valid", res_valid, 1'b0);
      check("done_ready", instr_ready, 1'b1);
      m_regs[w[5:4]] = r;
      m_z            = (r == 4'd0);
    end else begin
      if (w[9:8] == 2'b01) m_regs[w[5:4]] = w[3:0];
      if (w[9:8] == 2'b11 && SKIPZ_EN && m_z) m_skip = 1'b1;
      check("nonalu_idle", busy, 1'b0);
      check("nonalu_no_res", res_valid, 1'b0);
    end
  endtask

  function automatic logic [9:0] alu_w(input int sel, input int rd, input int rs1, input int rs2);
    return {2'b00, 2'(sel), 2'(rd), 2'(rs1), 2'(rs2)};
  endfunction

  function automatic logic [9:0] ldi_w(input int rd, input int imm);
    return {2'b01, 2'b00, 2'(rd), 4'(imm)};
  endfunction

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    res_ready   = 1'b0;
    last_dut    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_instr_ready", instr_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_all", {res_data, res_carry, res_zero}, 6'd0);
    check("rst_alu_all", {alu_a, alu_b, alu_sel}, 10'd0);

    // ADD with carry wrap: 9 + 8 = 1, carry 1.
    issue(ldi_w(0, 4'h9), 0);
    issue(ldi_w(1, 4'h8), 0);
    issue(alu_w(3, 2, 0, 1), 0);
    check("add_wrap_result", last_dut, 4'h1);

    // XOR to zero with a 5-cycle consumer stall.
    issue(alu_w(2, 3, 0, 0), 5);
    check("xor_zero_result", last_dut, 4'h0);

    // AND into a source register, then read it back.
    issue(ldi_w(0, 4'hC), 0);
    issue(ldi_w(1, 4'hA), 0);
    issue(alu_w(0, 0, 0, 1), 0);
    issue(alu_w(1, 1, 0, 0), 0);
    check("and_then_or", last_dut, 4'h8);

    // Reset asserted while the op is in EXEC: result discarded, registers cleared.
    check("pre_rst_ready", instr_ready, 1'b1);
    instr = alu_w(3, 2, 0, 1); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("mid_exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("post_rst_valid", res_valid, 1'b0);
    for (int r = 0; r < 4; r++) begin
      issue(alu_w(1, r, r, r), 0);
      check("post_rst_reg_zero", last_dut, 4'h0);
    end

    // Zero result, SKIPZ, LOADI r0=5, ADD r1 = r0 + r0.
    issue(ldi_w(0, 4'h3), 0);
    issue(alu_w(2, 3, 0, 0), 0);
    issue(10'b11_0000_0000, 0);
    issue(ldi_w(0, 4'h5), 0);
    issue(alu_w(3, 1, 0, 0), 0);
    check("skipz_sequence", last_dut, SKIPZ_EN ? 4'h6 : 4'hA);

    // Randomized instruction stream, including occasional idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      issue(10'($urandom), $urandom_range(0, 3));
    end

    // Final readback of all registers through the model.
    for (int r = 0; r < 4; r++) issue(alu_w(1, r, r, r), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
